i2c_master_ctrl: RTL

// - Single-transaction I2C master that drives the SCL/SDA bus feeding the on-chip memory slave.
// - Accepts one byte-write or byte-read request and serialises it on the bus: START, {op,addr[6:0]}, ACK, data, ACK/NACK, STOP.
// - Returns read data, an error flag and a one-cycle done pulse to the host.

---
 rtl/i2c_master_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C byte master: START, {op,addr}, ACK, data, ACK/NACK, STOP, then a done pulse.
// Optional address-NACK retry is enabled with the I2C_MASTER_RETRY_EN macro.
module i2c_master_ctrl #(
    parameter int sys_freq  = 40000000,
    parameter int i2c_freq  = 1000000,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       op,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic       scl,
    inout  wire        sda,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ack_err,
    output logic       done
);
    localparam int CLK_COUNT4 = sys_freq / i2c_freq;
    localparam int CLK_COUNT1 = CLK_COUNT4 / 4;
    localparam int CW = $clog2(CLK_COUNT4);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_COUNT4 - 1);
    localparam logic [CW-1:0] PRE1 = CW'(CLK_COUNT1 - 1);
    localparam logic [CW-1:0] PH1  = CW'(CLK_COUNT1);
    localparam logic [CW-1:0] PH2  = CW'(2 * CLK_COUNT1);
    localparam logic [CW-1:0] PH3  = CW'(3 * CLK_COUNT1);
`ifdef I2C_MASTER_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      bit_q, bit_d;
    logic            op_q, op_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      rd_sh_q, rd_sh_d;
    logic            ack_err_q, ack_err_d;
    logic            sda_low_q, sda_low_d;
    logic            sda_s_q, sda_s_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            again_q, again_d;

    logic       bit_end, chg, samp, sda_in, sda_low;
    logic [1:0] phase;
    logic [7:0] addr_byte;

    assign bit_end   = (count_q == LAST);
    assign chg       = (count_q == PRE1);
    assign samp      = (count_q == PH2);
    assign addr_byte = {op_q, addr_q};
    assign sda_in    = sda;

    always_comb begin
        if (count_q < PH1)      phase = 2'd0;
        else if (count_q < PH2) phase = 2'd1;
        else if (count_q < PH3) phase = 2'd2;
        else                    phase = 2'd3;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = bit_end ? '0 : count_q + 1'b1;
        bit_d     = bit_q;
        op_d      = op_q;
        addr_d    = addr_q;
        din_d     = din_q;
        dout_d    = dout_q;
        rd_sh_d   = rd_sh_q;
        ack_err_d = ack_err_q;
        sda_low_d = sda_low_q;
        sda_s_d   = samp ? sda_in : sda_s_q;
        retry_d   = retry_q;
        again_d   = again_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                bit_d   = '0;
                retry_d = '0;
                again_d = 1'b0;
                if (newd) begin
                    op_d      = op;
                    addr_d    = addr;
                    din_d     = din;
                    ack_err_d = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                // keep SDA low into the first address bit's low-SCL phase
                sda_low_d = 1'b1;
                if (bit_end) state_d = ADDR;
            end
            ADDR, WR_DATA: begin
                if (chg) sda_low_d = (state_q == ADDR) ? ~addr_byte[~bit_q] : ~din_q[~bit_q];
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
                end
            end
            ADDR_ACK: begin
                if (chg) sda_low_d = 1'b0;
                if (bit_end) begin
                    if (!sda_s_q) begin
                        state_d = op_q ? RD_DATA : WR_DATA;
                    end else if (RETRY_EN && (retry_q < RW'(MAX_RETRY))) begin
                        retry_d = retry_q + RW'(1);
                        again_d = 1'b1;
                        state_d = STOP;
                    end else begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end
                end
            end
            WR_ACK: begin
                if (chg) sda_low_d = 1'b0;
                if (bit_end) begin
                    if (sda_s_q) ack_err_d = 1'b1;
                    state_d = STOP;
                end
            end
            RD_DATA: begin
                if (chg) sda_low_d = 1'b0;
                if (samp) rd_sh_d = {rd_sh_q[6:0], sda_in};
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        dout_d  = rd_sh_q;
                        state_d = RD_NACK;
                    end
                end
            end
            RD_NACK: begin
                if (chg) sda_low_d = 1'b0;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    again_d = 1'b0;
                    state_d = again_q ? START : DONE;
                end
            end
            DONE: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bit_q     <= '0;
            op_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            rd_sh_q   <= '0;
            ack_err_q <= 1'b0;
            sda_low_q <= 1'b0;
            sda_s_q   <= 1'b1;
            retry_q   <= '0;
            again_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_q     <= bit_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            rd_sh_q   <= rd_sh_d;
            ack_err_q <= ack_err_d;
            sda_low_q <= sda_low_d;
            sda_s_q   <= sda_s_d;
            retry_q   <= retry_d;
            again_q   <= again_d;
        end
    end

    // START/STOP edges happen with SCL high, so they are decoded directly from the phase
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            IDLE, DONE: ;
            START: sda_low = phase[1];
            STOP: begin
                scl     = (phase != 2'd0);
                sda_low = ~phase[1];
            end
            default: begin
                scl     = phase[1];
                sda_low = sda_low_q;
            end
        endcase
    end

    assign sda     = sda_low ? 1'b0 : 1'bz;
    assign dout    = dout_q;
    assign ack_err = ack_err_q;
    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);
endmodule
